store_size_unit: RTL and testbench

- Store-side counterpart of the load-size path: performs SB/SH/SW writes into the byte-addressed, word-wide data memory.
- Byte and halfword stores use a read-modify-write. The unit reads the word at the address, replaces the low byte or halfword with the low bits of the store data, and writes the merged word back.
- Word stores write directly.
- The control FSM starts it with a one-cycle start pulse and waits for done.

---
 rtl/store_size_unit_if.sv | 24 ++
 rtl/store_size_unit.sv | 89 ++++++++
 tb/tb_store_size_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_size_unit_if.sv
// rtl/store_size_unit_if.sv - request and data-memory signals of the store size unit.
interface store_size_unit_if;
   logic        start;
   logic [1:0]  storeSel;
   logic [31:0] addr;
   logic [31:0] storeData;
   logic [31:0] memDataIn;
   logic [31:0] memAddr;
   logic [31:0] memDataOut;
   logic        memWr;
   logic        busy;
   logic        done;
   logic        alignErr;

   modport master (
      output start, storeSel, addr, storeData, memDataIn,
      input  memAddr, memDataOut, memWr, busy, done, alignErr
   );

   modport slave (
      input  start, storeSel, addr, storeData, memDataIn,
      output memAddr, memDataOut, memWr, busy, done, alignErr
   );
endinterface

// File: rtl/store_size_unit.sv
// rtl/store_size_unit.sv - SB/SH/SW store engine; sub-word stores read-modify-write the memory word.
module store_size_unit #(
   parameter int READ_LAT    = 1,
   parameter int CHECK_ALIGN = 0
) (
   input  logic clk,
   input  logic reset,
   store_size_unit_if.slave bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_MERGE = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

   logic [2:0]  r_state;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic [1:0]  r_sel;
   logic [31:0] r_merged;
   logic [2:0]  r_lat;

   logic        w_misaligned;
   logic [31:0] w_keep_mask;

   assign w_misaligned = (CHECK_ALIGN != 0) &&
                         (((bus.storeSel == 2'b01) && bus.addr[0]) ||
                          (bus.storeSel[1] && (bus.addr[1:0] != 2'b00)));

   // Memory bits above the stored byte/halfword survive the merge.
   assign w_keep_mask = (r_sel == 2'b01) ? 32'hFFFF_0000 : 32'hFFFF_FF00;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_data   <= '0;
         r_sel    <= '0;
         r_merged <= '0;
         r_lat    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_addr <= bus.addr;
                  r_sel  <= bus.storeSel;
                  r_data <= bus.storeData;
                  if (w_misaligned) begin
                     r_state <= S_ERR;
                  end else if (bus.storeSel[1]) begin
                     r_merged <= bus.storeData;
                     r_state  <= S_WRITE;
                  end else begin
                     r_lat   <= '0;
                     r_state <= S_READ;
                  end
               end
            end
            S_READ: begin
               r_lat <= r_lat + 3'd1;
               if (r_lat == LAT_LAST) begin
                  r_state <= S_MERGE;
               end
            end
            S_MERGE: begin
               r_merged <= (bus.memDataIn & w_keep_mask) | (r_data & ~w_keep_mask);
               r_state  <= S_WRITE;
            end
            S_WRITE: r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            S_ERR:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode straight from registers so reset clears them without waiting for a clock.
   assign bus.memAddr    = r_addr;
   assign bus.memDataOut = r_merged;
   assign bus.memWr      = (r_state == S_WRITE);
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.done       = (r_state == S_DONE);
   assign bus.alignErr   = (r_state == S_ERR);

endmodule

// File: tb/tb_store_size_unit.sv
// tb/tb_store_size_unit.sv - bench for store_size_unit with a word memory and a reference store model.
module tb_store_size_unit;

   typedef struct packed {
      logic [31:0] ma;
      logic [31:0] md;
      logic        wr;
      logic        busy;
      logic        done;
      logic        err;
   } obs_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_val;
   logic [31:0] rd0;
   logic [31:0] rd1a, rd1b, rd1c;

   store_size_unit_if if0 ();
   store_size_unit_if if1 ();

   store_size_unit #(.READ_LAT(1), .CHECK_ALIGN(0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0.slave)
   );

   store_size_unit #(.READ_LAT(3), .CHECK_ALIGN(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: dut0 sees data one cycle after the address, dut1 three cycles after.
   always @(posedge clk) begin
      if (pl_en)
         mem[pl_idx] <= pl_val;
      else if (if0.memWr)
         mem[if0.memAddr[7:2]] <= if0.memDataOut;
      else if (if1.memWr)
         mem[if1.memAddr[7:2]] <= if1.memDataOut;
      rd0  <= mem[if0.memAddr[7:2]];
      rd1a <= mem[if1.memAddr[7:2]];
      rd1b <= rd1a;
      rd1c <= rd1b;
   end

   assign if0.memDataIn = rd0;
   assign if1.memDataIn = rd1c;

   task automatic chk(input string tag, input logic [67:0] o, input logic [67:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic drive(input int u, input logic st, input logic [1:0] sel,
                        input logic [31:0] a, input logic [31:0] d);
      if (u == 0) begin
         if0.start = st; if0.storeSel = sel; if0.addr = a; if0.storeData = d;
      end else begin
         if1.start = st; if1.storeSel = sel; if1.addr = a; if1.storeData = d;
      end
   endtask

   function automatic obs_t sample(input int u);
      obs_t o;
      if (u == 0)
         o = {if0.memAddr, if0.memDataOut, if0.memWr, if0.busy, if0.done, if0.alignErr};
      else
         o = {if1.memAddr, if1.memDataOut, if1.memWr, if1.busy, if1.done, if1.alignErr};
      return o;
   endfunction

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      pl_en  = 1'b1;
      pl_idx = 6'(idx);
      pl_val = val;
      ref_mem[idx] = val;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // One store, observed for 12 cycles after the accepting edge and judged against the model.
   task automatic run_store(input int u, input logic [1:0] sel, input logic [31:0] a,
                            input logic [31:0] d, input bit poke_in);
      int          rl, idx, ew, wcyc, dcyc, ecyc, nw, nd, ne;
      bit          ca, mis, poke;
      logic [31:0] old, expw, wa, wd;
      logic        b1;
      obs_t        o;
      string       p;
      rl   = (u == 0) ? 1 : 3;
      ca   = (u == 1);
      idx  = int'(a[7:2]);
      mis  = ca && ((sel == 2'b01 && a[0]) || (sel[1] && a[1:0] != 2'b00));
      poke = poke_in && !mis;
      old  = ref_mem[idx];
      if (sel[1])
         expw = d;
      else if (sel == 2'b01)
         expw = (old / 32'd65536) * 32'd65536 + (d % 32'd65536);
      else
         expw = (old / 32'd256) * 32'd256 + (d % 32'd256);
      ew = sel[1] ? 1 : rl + 2;
      wcyc = 0; dcyc = 0; ecyc = 0; nw = 0; nd = 0; ne = 0;
      wa = '0; wd = '0; b1 = 1'b0;
      p = $sformatf("u%0d sel%0d a%0h", u, sel, a);

      @(negedge clk);
      drive(u, 1'b1, sel, a, d);
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         drive(u, poke && k >= 2 && k <= ew + 1, 2'($urandom_range(0, 3)),
               a ^ 32'h40, $urandom);
         o = sample(u);
         if (k == 1) b1 = o.busy;
         if (o.wr) begin
            nw++;
            if (wcyc == 0) begin wcyc = k; wa = o.ma; wd = o.md; end
         end
         if (o.done) begin nd++; if (dcyc == 0) dcyc = k; end
         if (o.err)  begin ne++; if (ecyc == 0) ecyc = k; end
      end

      chk({p, " busy_k1"}, 68'(b1), 68'(1));
      chk({p, " busy_end"}, 68'(o.busy), 68'(0));
      if (mis) begin
         chk({p, " err_cnt"}, 68'(ne), 68'(1));
         chk({p, " err_cyc"}, 68'(ecyc), 68'(1));
         chk({p, " wr_cnt"}, 68'(nw), 68'(0));
         chk({p, " done_cnt"}, 68'(nd), 68'(0));
      end else begin
         chk({p, " wr_cnt"}, 68'(nw), 68'(1));
         chk({p, " wr_cyc"}, 68'(wcyc), 68'(ew));
         chk({p, " wr_addr"}, 68'(wa), 68'(a));
         chk({p, " wr_data"}, 68'(wd), 68'(expw));
         chk({p, " done_cnt"}, 68'(nd), 68'(1));
         chk({p, " done_cyc"}, 68'(dcyc), 68'(ew + 1));
         chk({p, " err_cnt"}, 68'(ne), 68'(0));
         ref_mem[idx] = expw;
      end
      chk({p, " mem"}, 68'(mem[idx]), 68'(ref_mem[idx]));
   endtask

   initial begin
      obs_t o;
      n_cmp = 0;
      n_bad = 0;
      pl_en = 1'b0; pl_idx = '0; pl_val = '0;
      reset = 1'b0;
      drive(0, 1'b1, 2'b10, 32'h44, 32'h5555_5555);
      drive(1, 1'b1, 2'b00, 32'h48, 32'h6666_6666);
      for (int i = 0; i < 64; i++) preload(i, $urandom);
      @(negedge clk);
      chk("reset_outs_u0", 68'(sample(0)), 68'(0));
      chk("reset_outs_u1", 68'(sample(1)), 68'(0));
      drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
      drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_outs_u0", 68'(sample(0)), 68'(0));

      run_store(0, 2'b10, 32'h10, 32'hCAFE_BABE, 1'b0);
      preload(8, 32'h1122_3344);
      run_store(0, 2'b00, 32'h20, 32'hFFFF_FFAB, 1'b0);
      chk("sb_mem_112233AB", 68'(mem[8]), 68'(32'h1122_33AB));
      preload(16, 32'hAAAA_BBBB);
      run_store(1, 2'b01, 32'h40, 32'h0000_1234, 1'b0);
      chk("sh_mem_AAAA1234", 68'(mem[16]), 68'(32'hAAAA_1234));

      run_store(0, 2'b00, 32'h31, 32'h0000_00EE, 1'b1);
      run_store(1, 2'b01, 32'h52, 32'h0000_BEEF, 1'b1);
      run_store(0, 2'b11, 32'h64, 32'h0BAD_F00D, 1'b1);
      run_store(0, 2'b10, 32'h64, 32'h1357_9BDF, 1'b0);

      // Reset while an SB sits in MERGE: nothing may be written.
      @(negedge clk);
      drive(0, 1'b1, 2'b00, 32'h30, 32'h0000_0077);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
      @(negedge clk);
      chk("merge_busy", 68'(sample(0).busy), 68'(1));
      #2 reset = 1'b0;
      #1 chk("async_reset_outs", 68'(sample(0)), 68'(0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         o = sample(0);
         chk("reset_hold_wr_done", 68'({o.wr, o.done}), 68'(0));
      end
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         o = sample(0);
         chk("post_reset_idle", 68'({o.wr, o.done, o.busy}), 68'(0));
      end
      chk("reset_mem_kept", 68'(mem[12]), 68'(ref_mem[12]));

      run_store(1, 2'b01, 32'h21, 32'h0000_4444, 1'b0);
      run_store(1, 2'b10, 32'h22, 32'h9999_8888, 1'b0);
      run_store(1, 2'b00, 32'h23, 32'h0000_005A, 1'b0);
      run_store(0, 2'b10, 32'h22, 32'h7777_6666, 1'b0);

      for (int i = 0; i < 40; i++)
         run_store($urandom_range(0, 1), 2'($urandom_range(0, 3)),
                   32'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
